psychic5_rom_arbiter: RTL and testbench
=======================================

PSYCHIC5_ROM_ARBITER -- requirements
Module: psychic5_rom_arbiter

Interface
REQ-001 SHALL have parameter CH, default 3, number of requesting channels (2..8).
REQ-002 SHALL have parameter AW, default 17, address width per channel and on the SDRAM port.
REQ-003 SHALL have parameter DW, default 8, data width.
REQ-004 SHALL have parameter RR_MODE, default 1; 0 = fixed priority (ch0 highest), 1 = round-robin.
REQ-005 SHALL have port i_EMU_MCLK  in  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port i_EMU_INITRST_n  in  1  synchronous active-low reset.
REQ-007 SHALL have port i_FLUSH  in  1  invalidates all channel caches (ROM reload).
REQ-008 SHALL have port i_CH_ADDR  in  CH*AW  packed channel addresses; ch n at bits [n*AW +: AW].
REQ-009 SHALL have port i_CH_RQ_n  in  CH  per-channel read request, active low, level.
REQ-010 SHALL have port o_CH_DATA  out  CH*DW  packed per-channel cached read data.
REQ-011 SHALL have port o_CH_RDY  out  CH  per-channel data-valid for the current address.
REQ-012 SHALL have port o_SDRAM_ADDR  out  AW  address of the issued fetch.
REQ-013 SHALL have port o_SDRAM_RQ  out  1  one-cycle fetch strobe.
REQ-014 SHALL have port i_SDRAM_ACK  in  1  one-cycle completion strobe, data valid same cycle.
REQ-015 SHALL have port i_SDRAM_DATA  in  DW  fetched data.

Function
REQ-016 SHALL keep per channel a one-entry cache: valid bit, AW-bit tag, DW-bit data.
REQ-017 SHALL drive o_CH_RDY[n] = valid[n] AND tag[n] == channel n address, combinationally; o_CH_DATA[n] = data[n] registered, independent of request.
REQ-018 SHALL treat channel n as pending when i_CH_RQ_n[n]=0 and o_CH_RDY[n]=0.
REQ-019 SHALL implement states IDLE, ISSUE, WAIT; reset state IDLE.
REQ-020 IDLE: if any pending, SHALL latch winner index and its address into o_SDRAM_ADDR and go to ISSUE next edge; else stay.
REQ-021 ISSUE: SHALL hold o_SDRAM_RQ=1 for exactly this one cycle, then go to WAIT.
REQ-022 WAIT: on i_SDRAM_ACK=1 SHALL write i_SDRAM_DATA to winner's data, latched address to its tag, set its valid, and return to IDLE next edge.
REQ-023 Latency: request sampled pending at edge k -> o_SDRAM_RQ high cycle k+1 -> ACK earliest cycle k+2 -> o_CH_RDY/o_CH_DATA valid from cycle after ACK.
REQ-024 i_SDRAM_ACK outside WAIT SHALL be ignored.
REQ-025 RR_MODE=1: search SHALL start at (last_grant+1) mod CH; last_grant updates at IDLE->ISSUE.
REQ-026 RR_MODE=0: lowest pending index SHALL win.
REQ-027 Channel address change during fetch: fill SHALL still complete with the latched tag; channel reads not-ready and re-requests afterward.
REQ-028 i_FLUSH=1 SHALL clear all valid bits next edge; if asserted in WAIT, the pending fill SHALL be discarded (valid not set) but the FSM still waits for ACK.
REQ-029 Flush and ACK same cycle: flush wins; no valid set.
REQ-030 Releasing i_CH_RQ_n while in flight SHALL NOT abort the fetch.

Reset
REQ-031 While i_EMU_INITRST_n=0 at an edge: state IDLE, all valid=0, tags/data=0, o_SDRAM_RQ=0, o_SDRAM_ADDR=0, last_grant=CH-1 (ch0 first in round-robin).
REQ-032 Reset during WAIT SHALL abandon the fetch; a later ACK SHALL be ignored.

Verification
REQ-033 CH=3, ch1 RQ_n=0 addr 0x1234, ACK 3 cycles after RQ with 0xA5 -> o_SDRAM_ADDR=0x1234, RQ one cycle, o_CH_RDY[1]=1, data 0xA5 cycle after ACK; second read of 0x1234 issues no RQ.
REQ-034 RR_MODE=1, ch0..2 all pending continuously -> grant order 0,1,2,0; RR_MODE=0 -> 0 then 1 then 2 only as lower ones become ready.
REQ-035 ch0 addr 0x0010 -> 0x0011 mid-WAIT -> fill tagged 0x0010, RDY[0]=0, new RQ for 0x0011 follows.
REQ-036 i_FLUSH pulse during WAIT, ACK same cycle -> all RDY=0, no valid set, FSM IDLE next edge.
REQ-037 Reset asserted in WAIT, ACK after release -> outputs zero, ACK ignored, no RDY.

Source files
------------

// File: rtl/psychic5_rom_arbiter.sv
// Shares one SDRAM read port among CH ROM channels, each fronted by a
// single-entry cache; fixed-priority or round-robin arbitration.
module psychic5_rom_arbiter #(
   parameter int unsigned CH      = 3,
   parameter int unsigned AW      = 17,
   parameter int unsigned DW      = 8,
   parameter int unsigned RR_MODE = 1
) (
   input  logic             i_EMU_MCLK,
   input  logic             i_EMU_INITRST_n,
   input  logic             i_FLUSH,
   input  logic [CH*AW-1:0] i_CH_ADDR,
   input  logic [CH-1:0]    i_CH_RQ_n,
   output logic [CH*DW-1:0] o_CH_DATA,
   output logic [CH-1:0]    o_CH_RDY,
   output logic [AW-1:0]    o_SDRAM_ADDR,
   output logic             o_SDRAM_RQ,
   input  logic             i_SDRAM_ACK,
   input  logic [DW-1:0]    i_SDRAM_DATA
);

   localparam int unsigned IW = (CH > 1) ? $clog2(CH) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

   state_t                state_q, state_d;
   logic [CH-1:0]         valid_q, valid_d;
   logic [CH-1:0][AW-1:0] tag_q, tag_d;
   logic [CH-1:0][DW-1:0] data_q, data_d;
   logic [AW-1:0]         addr_q, addr_d;
   logic [IW-1:0]         win_q, win_d;
   logic [IW-1:0]         last_q, last_d;
   logic                  rq_q, rq_d;
   logic                  drop_q, drop_d;

   logic [CH-1:0][AW-1:0] ch_addr;
   logic [CH-1:0]         rdy_c;
   logic [CH-1:0]         pend_c;
   logic                  found_c;
   logic [IW-1:0]         sel_c;
   logic [IW-1:0]         cand_c;

   assign ch_addr = i_CH_ADDR;

   // Cache hit: entry valid and tagged with the channel's present address.
   always_comb begin : hit
      rdy_c = '0;
      for (int n = 0; n < int'(CH); n++) begin
         rdy_c[n] = valid_q[n] && (tag_q[n] == ch_addr[n]);
      end
   end

   assign pend_c = ~i_CH_RQ_n & ~rdy_c;

   // Round-robin scans from the channel after the last grant; fixed scans from 0.
   always_comb begin : arbitrate
      found_c = 1'b0;
      sel_c   = '0;
      cand_c  = '0;
      for (int i = 0; i < int'(CH); i++) begin
         if (RR_MODE != 0) cand_c = IW'((int'(last_q) + 1 + i) % int'(CH));
         else              cand_c = IW'(i);
         if (!found_c && pend_c[cand_c]) begin
            found_c = 1'b1;
            sel_c   = cand_c;
         end
      end
   end

   always_ff @(posedge i_EMU_MCLK) begin : state_reg
      if (!i_EMU_INITRST_n) state_q <= ST_IDLE;
      else                  state_q <= state_d;
   end

   always_comb begin : next_state
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (found_c) state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT:  if (i_SDRAM_ACK) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin : outputs
      addr_d  = addr_q;
      win_d   = win_q;
      last_d  = last_q;
      rq_d    = 1'b0;
      drop_d  = drop_q;
      valid_d = valid_q;
      tag_d   = tag_q;
      data_d  = data_q;
      case (state_q)
         ST_IDLE: begin
            if (found_c) begin
               rq_d   = 1'b1;
               win_d  = sel_c;
               last_d = sel_c;
               addr_d = ch_addr[sel_c];
               drop_d = 1'b0;
            end
         end
         ST_WAIT: begin
            if (i_SDRAM_ACK && !drop_q && !i_FLUSH) begin
               valid_d[win_q] = 1'b1;
               tag_d[win_q]   = addr_q;
               data_d[win_q]  = i_SDRAM_DATA;
            end
         end
         default: ;
      endcase
      // A flush while a fetch is outstanding poisons that fill.
      if (i_FLUSH) begin
         valid_d = '0;
         if (state_q != ST_IDLE) drop_d = 1'b1;
      end
   end

   always_ff @(posedge i_EMU_MCLK) begin : datapath_reg
      if (!i_EMU_INITRST_n) begin
         valid_q <= '0;
         tag_q   <= '0;
         data_q  <= '0;
         addr_q  <= '0;
         win_q   <= '0;
         last_q  <= IW'(CH - 1);
         rq_q    <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         tag_q   <= tag_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
         win_q   <= win_d;
         last_q  <= last_d;
         rq_q    <= rq_d;
         drop_q  <= drop_d;
      end
   end

   assign o_CH_RDY     = rdy_c;
   assign o_CH_DATA    = data_q;
   assign o_SDRAM_ADDR = addr_q;
   assign o_SDRAM_RQ   = rq_q;

endmodule

// File: tb/tb_psychic5_rom_arbiter.sv
// Scoreboard bench: round-robin and fixed-priority instances share stimulus;
// a transaction-level cache/fetch model predicts grants, readiness and data.
module tb_psychic5_rom_arbiter;

   localparam int unsigned CH = 3;
   localparam int unsigned AW = 17;
   localparam int unsigned DW = 8;

   logic                  clk;
   logic                  rst_n;
   logic                  flush;
   logic [CH-1:0][AW-1:0] ch_addr;
   logic [CH-1:0]         rq_n;
   logic [DW-1:0]         sd_data;
   logic [1:0]            ack;

   logic [CH*DW-1:0] data_o  [2];
   logic [CH-1:0]    rdy_o   [2];
   logic [AW-1:0]    saddr_o [2];
   logic             srq_o   [2];

   psychic5_rom_arbiter #(.CH(CH), .AW(AW), .DW(DW), .RR_MODE(1)) u_rr (
      .i_EMU_MCLK(clk), .i_EMU_INITRST_n(rst_n), .i_FLUSH(flush),
      .i_CH_ADDR(ch_addr), .i_CH_RQ_n(rq_n),
      .o_CH_DATA(data_o[0]), .o_CH_RDY(rdy_o[0]),
      .o_SDRAM_ADDR(saddr_o[0]), .o_SDRAM_RQ(srq_o[0]),
      .i_SDRAM_ACK(ack[0]), .i_SDRAM_DATA(sd_data)
   );

   psychic5_rom_arbiter #(.CH(CH), .AW(AW), .DW(DW), .RR_MODE(0)) u_fx (
      .i_EMU_MCLK(clk), .i_EMU_INITRST_n(rst_n), .i_FLUSH(flush),
      .i_CH_ADDR(ch_addr), .i_CH_RQ_n(rq_n),
      .o_CH_DATA(data_o[1]), .o_CH_RDY(rdy_o[1]),
      .o_SDRAM_ADDR(saddr_o[1]), .o_SDRAM_RQ(srq_o[1]),
      .i_SDRAM_ACK(ack[1]), .i_SDRAM_DATA(sd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state, index 0 = round-robin instance, 1 = fixed priority.
   logic [CH-1:0] m_valid [2];
   logic [AW-1:0] m_tag   [2][CH];
   logic [DW-1:0] m_data  [2][CH];
   logic [AW-1:0] m_addr  [2];
   int            m_last  [2];
   bit            fl_on   [2];
   int            fl_age  [2];
   int            fl_ch   [2];
   bit            fl_drop [2];
   logic [AW-1:0] q0 [$];
   logic [AW-1:0] q1 [$];

   int total = 0;
   int bad   = 0;

   int cnt [2];
   int fix_dly;
   bit rnd, flush_ack, rst_wait;

   task automatic chk(input string nm, input int m, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d] @%0t actual=%0h required=%0h", nm, m, $time, act, exp);
      end
   endtask

   task automatic model_step(input int m);
      bit pend [CH];
      bit found;
      bit was_on;
      int c;
      if (!rst_n) begin
         m_valid[m] = '0;
         for (int n = 0; n < int'(CH); n++) begin
            m_tag[m][n]  = '0;
            m_data[m][n] = '0;
         end
         m_addr[m]  = '0;
         m_last[m]  = CH - 1;
         fl_on[m]   = 1'b0;
         fl_drop[m] = 1'b0;
         return;
      end
      for (int n = 0; n < int'(CH); n++)
         pend[n] = !rq_n[n] && !(m_valid[m][n] && (m_tag[m][n] == ch_addr[n]));
      was_on = fl_on[m];
      if (fl_on[m]) begin
         // first in-flight cycle is the strobe; completions only count after it
         if (fl_age[m] == 0) fl_age[m] = 1;
         else if (ack[m]) begin
            if (!fl_drop[m] && !flush) begin
               m_valid[m][fl_ch[m]] = 1'b1;
               m_tag[m][fl_ch[m]]   = m_addr[m];
               m_data[m][fl_ch[m]]  = sd_data;
            end
            fl_on[m] = 1'b0;
         end
      end else begin
         found = 1'b0;
         for (int i = 0; i < int'(CH); i++) begin
            c = (m == 0) ? (m_last[m] + 1 + i) % CH : i;
            if (!found && pend[c]) begin
               found    = 1'b1;
               fl_ch[m] = c;
            end
         end
         if (found) begin
            m_addr[m]  = ch_addr[fl_ch[m]];
            m_last[m]  = fl_ch[m];
            fl_on[m]   = 1'b1;
            fl_age[m]  = 0;
            fl_drop[m] = 1'b0;
            if (m == 0) q0.push_back(m_addr[m]);
            else        q1.push_back(m_addr[m]);
         end
      end
      if (flush) begin
         m_valid[m] = '0;
         if (was_on) fl_drop[m] = 1'b1;
      end
   endtask

   always @(posedge clk) begin
      for (int m = 0; m < 2; m++) model_step(m);
   end

   task automatic monitor_inst(input int m);
      logic [CH-1:0]    er;
      logic [CH*DW-1:0] ed;
      logic [AW-1:0]    ea;
      bit               has;
      for (int n = 0; n < int'(CH); n++) begin
         er[n]          = m_valid[m][n] && (m_tag[m][n] == ch_addr[n]);
         ed[n*DW +: DW] = m_data[m][n];
      end
      has = (m == 0) ? (q0.size() > 0) : (q1.size() > 0);
      chk("sdram_rq", m, 64'(srq_o[m]), 64'(has));
      if (has) begin
         ea = (m == 0) ? q0.pop_front() : q1.pop_front();
         chk("grant_addr", m, 64'(saddr_o[m]), 64'(ea));
      end
      chk("sdram_addr", m, 64'(saddr_o[m]), 64'(m_addr[m]));
      chk("ch_rdy", m, 64'(rdy_o[m]), 64'(er));
      chk("ch_data", m, 64'(data_o[m]), 64'(ed));
   endtask

   always @(negedge clk) begin
      for (int m = 0; m < 2; m++) monitor_inst(m);
   end

   // One stimulus cycle: SDRAM responder per instance plus optional random inputs.
   task automatic drive_cycle();
      @(negedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
         if (srq_o[m]) begin
            cnt[m] = (fix_dly != 0) ? fix_dly : int'($urandom_range(1, 4));
            ack[m] = 1'b0;
         end else if (cnt[m] > 0) begin
            cnt[m]--;
            ack[m] = (cnt[m] == 0);
         end else begin
            ack[m] = rnd && ($urandom_range(0, 24) == 0);
         end
      end
      if (rnd) begin
         rst_n   = ($urandom_range(0, 199) != 0);
         flush   = ($urandom_range(0, 39) == 0);
         sd_data = DW'($urandom);
         for (int n = 0; n < int'(CH); n++) begin
            if ($urandom_range(0, 3) == 0) rq_n[n] = ~rq_n[n];
            if ($urandom_range(0, 7) == 0) ch_addr[n] = AW'(n * 16 + int'($urandom_range(0, 3)));
         end
      end
      if (flush_ack) flush = ack[0];
      if (rst_wait)  rst_n = !(cnt[0] == 1);
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; rq_n = '1; ch_addr = '0; ack = '0; sd_data = '0;
      cnt[0] = 0; cnt[1] = 0;
      rnd = 1'b0; fix_dly = 3; flush_ack = 1'b0; rst_wait = 1'b0;
      repeat (3) drive_cycle();

      // single channel fetch, then a repeat read that must hit
      rst_n = 1'b1; ch_addr[1] = 17'h01234; rq_n = 3'b101; sd_data = 8'hA5;
      repeat (20) drive_cycle();

      // all channels pending continuously
      ch_addr[0] = 17'h00100; ch_addr[1] = 17'h00200; ch_addr[2] = 17'h00300;
      rq_n = '0; sd_data = 8'h3C;
      repeat (40) drive_cycle();

      // address changes while the fill is in flight
      ch_addr[0] = 17'h00010; rq_n = 3'b110; fix_dly = 4; sd_data = 8'h5A;
      repeat (3) drive_cycle();
      ch_addr[0] = 17'h00011;
      repeat (15) drive_cycle();

      // flush coinciding with the completion strobe
      flush_ack = 1'b1; fix_dly = 2; ch_addr[2] = 17'h00301; rq_n = 3'b011;
      repeat (12) drive_cycle();
      flush_ack = 1'b0; flush = 1'b0;
      repeat (8) drive_cycle();

      // reset while waiting, completion arrives after release
      ch_addr[1] = 17'h00222; rq_n = 3'b101; rst_wait = 1'b1; fix_dly = 3;
      repeat (12) drive_cycle();
      rst_wait = 1'b0; rst_n = 1'b1;
      repeat (4) drive_cycle();

      rnd = 1'b1; fix_dly = 0;
      repeat (4000) drive_cycle();

      rnd = 1'b0; rst_n = 1'b1; flush = 1'b0; rq_n = '1;
      repeat (10) drive_cycle();

      chk("grants_left", 0, 64'(q0.size()), 64'd0);
      chk("grants_left", 1, 64'(q1.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
